// File: rtl/sysid_probe_pkg.sv
// Shared types and constants for the system-ID probe master.
// Holds the probe FSM encoding, word addresses and counter width.
package sysid_probe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        WAIT_ID,
        REQ_TS,
        WAIT_TS,
        CHECK,
        DONE
    } sysid_state_e;

    localparam logic SYSID_ADDR_ID = 1'b0;
    localparam logic SYSID_ADDR_TS = 1'b1;

    localparam int SYSID_CNT_W = 16;

endpackage

// File: rtl/sysid_read_engine.sv
// Single-word Avalon-MM read with waitrequest, readdatavalid and timeout.
// The phase (request / wait) is supplied by the sequencing FSM.
module sysid_read_engine
    import sysid_probe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_clr,
    input  logic        i_req,
    input  logic        i_wait,
    input  logic        i_addr,
    input  logic        i_waitrequest,
    input  logic        i_readdatavalid,
    input  logic [31:0] i_readdata,
    output logic        o_read,
    output logic        o_address,
    output logic        o_accept,
    output logic        o_capture,
    output logic        o_timeout,
    output logic [31:0] o_data
);

    localparam logic [SYSID_CNT_W-1:0] LP_LAST =
        SYSID_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [SYSID_CNT_W-1:0] r_cnt;
    logic                   w_active;

    assign w_active  = i_req | i_wait;
    assign o_read    = i_req;
    assign o_address = i_req & i_addr;
    assign o_accept  = i_req & ~i_waitrequest;
    // Zero-latency data may arrive in the accept cycle itself.
    assign o_capture = (o_accept | i_wait) & i_readdatavalid;
    // Completion in the last allowed cycle wins over the abort.
    assign o_timeout = w_active & ~o_capture & (r_cnt == LP_LAST);
    assign o_data    = i_readdata;

    // Cycles spent in the current transaction; restarts per word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr | o_capture | o_timeout) begin
            r_cnt <= '0;
        end else if (w_active) begin
            r_cnt <= r_cnt + SYSID_CNT_W'(1);
        end
    end

endmodule

// File: rtl/sysid_probe_master.sv
// Avalon-MM probe that reads the system-ID and build timestamp words
// and reports whether both match the values expected at build time.
module sysid_probe_master
    import sysid_probe_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1711549111,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysid_state_e r_state;
    sysid_state_e w_next;

    logic        r_first;
    logic        r_done;
    logic        r_id_ok;
    logic        r_ts_ok;
    logic        r_timeout_err;
    logic [31:0] r_id_value;
    logic [31:0] r_ts_value;

    logic        w_req;
    logic        w_wait;
    logic        w_addr;
    logic        w_launch;
    logic        w_cap_id;
    logic        w_cap_ts;
    logic        w_check;
    logic        w_abort;
    logic        w_finish;
    logic        w_accept;
    logic        w_capture;
    logic        w_timeout;
    logic [31:0] w_data;

    assign w_req  = (r_state == REQ_ID) || (r_state == REQ_TS);
    assign w_wait = (r_state == WAIT_ID) || (r_state == WAIT_TS);
    assign w_addr = ((r_state == REQ_TS) || (r_state == WAIT_TS))
                  ? SYSID_ADDR_TS : SYSID_ADDR_ID;

    sysid_read_engine #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_engine (
        .clock           (clock),
        .reset_n         (reset_n),
        .i_clr           (w_launch),
        .i_req           (w_req),
        .i_wait          (w_wait),
        .i_addr          (w_addr),
        .i_waitrequest   (avm_waitrequest),
        .i_readdatavalid (avm_readdatavalid),
        .i_readdata      (avm_readdata),
        .o_read          (avm_read),
        .o_address       (avm_address),
        .o_accept        (w_accept),
        .o_capture       (w_capture),
        .o_timeout       (w_timeout),
        .o_data          (w_data)
    );

    // Probe sequencing: next state and one-cycle datapath strobes.
    always_comb begin
        w_next   = r_state;
        w_launch = 1'b0;
        w_cap_id = 1'b0;
        w_cap_ts = 1'b0;
        w_check  = 1'b0;
        w_abort  = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start || (r_first && AUTO_START)) begin
                    w_launch = 1'b1;
                    w_next   = REQ_ID;
                end
            end
            REQ_ID: begin
                if (w_capture) begin
                    w_cap_id = 1'b1;
                    w_next   = REQ_TS;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = DONE;
                end else if (w_accept) begin
                    w_next = WAIT_ID;
                end
            end
            WAIT_ID: begin
                if (w_capture) begin
                    w_cap_id = 1'b1;
                    w_next   = REQ_TS;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = DONE;
                end
            end
            REQ_TS: begin
                if (w_capture) begin
                    w_cap_ts = 1'b1;
                    w_next   = CHECK;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = DONE;
                end else if (w_accept) begin
                    w_next = WAIT_TS;
                end
            end
            WAIT_TS: begin
                if (w_capture) begin
                    w_cap_ts = 1'b1;
                    w_next   = CHECK;
                end else if (w_timeout) begin
                    w_abort = 1'b1;
                    w_next  = DONE;
                end
            end
            CHECK: begin
                w_check = 1'b1;
                w_next  = DONE;
            end
            DONE: begin
                w_finish = 1'b1;
                w_next   = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // State register; r_first marks the first cycle after reset release.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_first <= 1'b1;
        end else begin
            r_state <= w_next;
            r_first <= 1'b0;
        end
    end

    // Result registers: cleared on launch, filled as the probe advances.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_done        <= 1'b0;
            r_id_ok       <= 1'b0;
            r_ts_ok       <= 1'b0;
            r_timeout_err <= 1'b0;
            r_id_value    <= '0;
            r_ts_value    <= '0;
        end else begin
            if (w_launch) begin
                r_done        <= 1'b0;
                r_id_ok       <= 1'b0;
                r_ts_ok       <= 1'b0;
                r_timeout_err <= 1'b0;
            end
            if (w_cap_id) begin
                r_id_value <= w_data;
            end
            if (w_cap_ts) begin
                r_ts_value <= w_data;
            end
            if (w_check) begin
                r_id_ok <= (r_id_value == EXPECTED_ID);
                r_ts_ok <= (r_ts_value == EXPECTED_TS);
            end
            if (w_abort) begin
                r_timeout_err <= 1'b1;
                r_id_ok       <= 1'b0;
                r_ts_ok       <= 1'b0;
            end
            if (w_finish) begin
                r_done <= 1'b1;
            end
        end
    end

    assign busy        = (r_state != IDLE) && (r_state != DONE);
    assign done        = r_done;
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout_err = r_timeout_err;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

endmodule

// File: tb/tb_sysid_probe_master.sv
// Self-checking bench for sysid_probe_master.
// Behavioural Avalon slave plus a per-probe timing/result model.
module tb_sysid_probe_master;

    localparam logic [31:0] EXP_ID = 32'd0;
    localparam logic [31:0] EXP_TS = 32'd1711549111;
    localparam int          TO     = 20;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest   = 1'b0;
    logic [31:0] avm_readdata      = '0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy;
    logic        done;
    logic        id_ok;
    logic        ts_ok;
    logic        timeout_err;
    logic [31:0] id_value;
    logic [31:0] ts_value;

    int total = 0;
    int bad   = 0;

    // slave configuration per word: wait states, latency, data
    int          cfg_w [2];
    int          cfg_l [2];
    logic [31:0] cfg_d [2];

    int          probe_gen = 0;
    int          accepts   = 0;
    int          viol      = 0;
    int          wcnt      = 0;
    int          pend      = 0;
    int          pend_gen  = 0;
    logic [31:0] pend_data = '0;
    logic        prev_stall = 1'b0;
    logic        prev_addr  = 1'b0;

    logic [31:0] m_id = '0;
    logic [31:0] m_ts = '0;
    int          lat;
    logic        busy1;

    sysid_probe_master #(
        .EXPECTED_ID    (EXP_ID),
        .EXPECTED_TS    (EXP_TS),
        .TIMEOUT_CYCLES (TO),
        .AUTO_START     (1'b1)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .busy              (busy),
        .done              (done),
        .id_ok             (id_ok),
        .ts_ok             (ts_ok),
        .timeout_err       (timeout_err),
        .id_value          (id_value),
        .ts_value          (ts_value)
    );

    always #5 clock = ~clock;

    // Avalon slave: decides stall/response on the falling edge
    always @(negedge clock) begin
        int idx;
        avm_readdatavalid = 1'b0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = $urandom;
        if (!reset_n) begin
            pend       = 0;
            wcnt       = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall &&
                (avm_read !== 1'b1 || avm_address !== prev_addr))
                viol++;
            prev_stall = 1'b0;
            if (pend > 0 && pend_gen == probe_gen) begin
                pend--;
                if (pend == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pend_data;
                end
            end
            if (avm_read === 1'b1) begin
                idx = (avm_address === 1'b1) ? 1 : 0;
                if (wcnt < cfg_w[idx]) begin
                    avm_waitrequest = 1'b1;
                    wcnt++;
                    prev_stall = 1'b1;
                    prev_addr  = avm_address;
                end else begin
                    wcnt = 0;
                    accepts++;
                    if (cfg_l[idx] == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata      = cfg_d[idx];
                    end else begin
                        pend      = cfg_l[idx];
                        pend_data = cfg_d[idx];
                        pend_gen  = probe_gen;
                    end
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    task automatic set_cfg(input int w0, input int l0,
                           input logic [31:0] d0,
                           input int w1, input int l1,
                           input logic [31:0] d1);
        cfg_w[0] = w0; cfg_l[0] = l0; cfg_d[0] = d0;
        cfg_w[1] = w1; cfg_l[1] = l1; cfg_d[1] = d1;
    endtask

    // Reference: a word takes w+1+l cycles; it fails if longer than TO.
    // done rises after both words plus one check and one done cycle.
    task automatic model_probe(output int e_lat,
                               output logic [2:0] e_f);
        int len0, len1;
        len0 = cfg_w[0] + 1 + cfg_l[0];
        len1 = cfg_w[1] + 1 + cfg_l[1];
        if (len0 > TO) begin
            e_lat = TO + 1;
            e_f   = 3'b001;
        end else begin
            m_id = cfg_d[0];
            if (len1 > TO) begin
                e_lat = len0 + TO + 1;
                e_f   = 3'b001;
            end else begin
                m_ts  = cfg_d[1];
                e_lat = len0 + len1 + 2;
                e_f   = {m_id == EXP_ID, m_ts == EXP_TS, 1'b0};
            end
        end
    endtask

    // Launch (start pulse or reset release) and count edges to done.
    task automatic launch_and_wait(input bit use_start, input bit dup);
        probe_gen++;
        if (use_start) begin
            @(negedge clock);
            start = 1'b1;
        end
        @(posedge clock);
        #1 start = 1'b0;
        lat   = -1;
        busy1 = 1'b0;
        for (int k = 1; k <= 400; k++) begin
            if (dup && k == 1) start = 1'b1;
            @(posedge clock);
            #1 start = 1'b0;
            if (k == 1) busy1 = busy;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({busy, done, id_ok, ts_ok, timeout_err, avm_read,
             avm_address} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b exp=0",
                     {busy, done, id_ok, ts_ok, timeout_err,
                      avm_read, avm_address});
        end
        total++;
        if ({id_value, ts_value} !== 64'b0) begin
            bad++;
            $display("FAIL reset_values got=%h/%h exp=0/0",
                     id_value, ts_value);
        end
    endtask

    task automatic test_autostart;
        int e_lat;
        logic [2:0] e_f;
        set_cfg(0, 1, EXP_ID, 0, 1, EXP_TS);
        model_probe(e_lat, e_f);
        @(negedge clock);
        reset_n = 1'b1;
        launch_and_wait(0, 0);
        total++;
        if (lat != e_lat) begin
            bad++;
            $display("FAIL auto_lat got=%0d exp=%0d", lat, e_lat);
        end
        total++;
        if ({id_ok, ts_ok, timeout_err} !== e_f) begin
            bad++;
            $display("FAIL auto_flags got=%b exp=%b",
                     {id_ok, ts_ok, timeout_err}, e_f);
        end
        total++;
        if (busy1 !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL auto_busy got=%b%b exp=10", busy1, busy);
        end
        total++;
        if (ts_value !== m_ts) begin
            bad++;
            $display("FAIL auto_ts got=%h exp=%h", ts_value, m_ts);
        end
        repeat (10) @(posedge clock);
    endtask

    task automatic test_bad_ts;
        int e_lat;
        logic [2:0] e_f;
        set_cfg(0, 1, EXP_ID, 0, 1, 32'h12345678);
        model_probe(e_lat, e_f);
        launch_and_wait(1, 0);
        total++;
        if (lat != e_lat) begin
            bad++;
            $display("FAIL badts_lat got=%0d exp=%0d", lat, e_lat);
        end
        total++;
        if ({id_ok, ts_ok, timeout_err} !== e_f) begin
            bad++;
            $display("FAIL badts_flags got=%b exp=%b",
                     {id_ok, ts_ok, timeout_err}, e_f);
        end
        total++;
        if (ts_value !== m_ts) begin
            bad++;
            $display("FAIL badts_ts got=%h exp=%h", ts_value, m_ts);
        end
        repeat (5) @(posedge clock);
        #1;
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_sticky got=%b exp=1", done);
        end
        repeat (5) @(posedge clock);
    endtask

    task automatic test_waitreq;
        int e_lat, v0;
        logic [2:0] e_f;
        v0 = viol;
        set_cfg(10, 1, EXP_ID, 0, 1, EXP_TS);
        model_probe(e_lat, e_f);
        launch_and_wait(1, 0);
        total++;
        if (lat != e_lat) begin
            bad++;
            $display("FAIL wait_lat got=%0d exp=%0d", lat, e_lat);
        end
        total++;
        if (viol - v0 != 0) begin
            bad++;
            $display("FAIL wait_stable got=%0d exp=0", viol - v0);
        end
        total++;
        if ({id_ok, ts_ok, timeout_err} !== e_f) begin
            bad++;
            $display("FAIL wait_flags got=%b exp=%b",
                     {id_ok, ts_ok, timeout_err}, e_f);
        end
        repeat (10) @(posedge clock);
    endtask

    task automatic test_timeout;
        int e_lat;
        logic [2:0] e_f;
        set_cfg(0, 25, 32'hDEAD0001, 0, 1, EXP_TS);
        model_probe(e_lat, e_f);
        launch_and_wait(1, 0);
        total++;
        if (lat != e_lat) begin
            bad++;
            $display("FAIL to0_lat got=%0d exp=%0d", lat, e_lat);
        end
        total++;
        if ({id_ok, ts_ok, timeout_err, avm_read} !== {e_f, 1'b0}) begin
            bad++;
            $display("FAIL to0_flags got=%b exp=%b",
                     {id_ok, ts_ok, timeout_err, avm_read}, {e_f, 1'b0});
        end
        repeat (10) @(posedge clock);
        #1;
        total++;
        if (id_value !== m_id) begin
            bad++;
            $display("FAIL to0_late got=%h exp=%h", id_value, m_id);
        end
        set_cfg(0, 1, 32'h0BAD0002, 40, 1, 32'h55555555);
        model_probe(e_lat, e_f);
        launch_and_wait(1, 0);
        total++;
        if (lat != e_lat) begin
            bad++;
            $display("FAIL to1_lat got=%0d exp=%0d", lat, e_lat);
        end
        total++;
        if ({id_ok, ts_ok, timeout_err, avm_read} !== {e_f, 1'b0}) begin
            bad++;
            $display("FAIL to1_flags got=%b exp=%b",
                     {id_ok, ts_ok, timeout_err, avm_read}, {e_f, 1'b0});
        end
        total++;
        if ({id_value, ts_value} !== {m_id, m_ts}) begin
            bad++;
            $display("FAIL to1_values got=%h/%h exp=%h/%h",
                     id_value, ts_value, m_id, m_ts);
        end
        repeat (10) @(posedge clock);
    endtask

    task automatic test_zero_latency;
        int e_lat;
        logic [2:0] e_f;
        set_cfg(0, 0, EXP_ID, 0, 0, EXP_TS);
        model_probe(e_lat, e_f);
        launch_and_wait(1, 0);
        total++;
        if (lat != e_lat) begin
            bad++;
            $display("FAIL zl_lat got=%0d exp=%0d", lat, e_lat);
        end
        total++;
        if ({id_ok, ts_ok, timeout_err} !== e_f) begin
            bad++;
            $display("FAIL zl_flags got=%b exp=%b",
                     {id_ok, ts_ok, timeout_err}, e_f);
        end
        repeat (5) @(posedge clock);
        set_cfg(2, 0, 32'h00000007, 1, 0, EXP_TS);
        model_probe(e_lat, e_f);
        launch_and_wait(1, 0);
        total++;
        if (lat != e_lat || id_value !== m_id) begin
            bad++;
            $display("FAIL zl2 got=%0d/%h exp=%0d/%h",
                     lat, id_value, e_lat, m_id);
        end
        repeat (5) @(posedge clock);
    endtask

    task automatic test_reset_mid;
        int e_lat, a0;
        logic [2:0] e_f;
        set_cfg(0, 1, 32'hCAFE0001, 3, 5, EXP_TS);
        probe_gen++;
        @(negedge clock);
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        total++;
        if ({avm_read, avm_address, id_value} !==
            {2'b11, 32'hCAFE0001}) begin
            bad++;
            $display("FAIL mid_reqts got=%b%b/%h exp=11/cafe0001",
                     avm_read, avm_address, id_value);
        end
        repeat (4) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, id_ok, ts_ok, timeout_err, avm_read,
             avm_address, id_value, ts_value} !== 71'b0) begin
            bad++;
            $display("FAIL mid_reset got=%b %h %h exp=0",
                     {busy, done, id_ok, ts_ok, timeout_err,
                      avm_read, avm_address}, id_value, ts_value);
        end
        m_id = '0;
        m_ts = '0;
        repeat (2) @(posedge clock);
        set_cfg(0, 1, EXP_ID, 0, 1, EXP_TS);
        model_probe(e_lat, e_f);
        a0 = accepts;
        @(negedge clock);
        reset_n = 1'b1;
        launch_and_wait(0, 1);
        total++;
        if (lat != e_lat) begin
            bad++;
            $display("FAIL mid_lat got=%0d exp=%0d", lat, e_lat);
        end
        repeat (15) @(posedge clock);
        #1;
        total++;
        if (accepts - a0 != 2 || done !== 1'b1) begin
            bad++;
            $display("FAIL mid_single got=%0d/%b exp=2/1",
                     accepts - a0, done);
        end
    endtask

    task automatic test_random;
        int e_lat, w0, l0, w1, l1;
        logic [31:0] d0, d1;
        logic [2:0] e_f;
        bit dup;
        for (int i = 0; i < 10; i++) begin
            w0 = $urandom_range(0, 3);
            w1 = $urandom_range(0, 3);
            l0 = ($urandom_range(0, 7) == 0) ? 25 : $urandom_range(0, 3);
            l1 = ($urandom_range(0, 7) == 0) ? 25 : $urandom_range(0, 3);
            d0 = $urandom_range(0, 1) ? EXP_ID : 32'($urandom);
            d1 = $urandom_range(0, 1) ? EXP_TS : 32'($urandom);
            dup = 1'($urandom_range(0, 1));
            set_cfg(w0, l0, d0, w1, l1, d1);
            model_probe(e_lat, e_f);
            launch_and_wait(1, dup);
            total++;
            if (lat != e_lat) begin
                bad++;
                $display("FAIL rnd%0d_lat got=%0d exp=%0d",
                         i, lat, e_lat);
            end
            total++;
            if ({id_ok, ts_ok, timeout_err} !== e_f) begin
                bad++;
                $display("FAIL rnd%0d_flags got=%b exp=%b",
                         i, {id_ok, ts_ok, timeout_err}, e_f);
            end
            total++;
            if ({id_value, ts_value} !== {m_id, m_ts}) begin
                bad++;
                $display("FAIL rnd%0d_values got=%h/%h exp=%h/%h",
                         i, id_value, ts_value, m_id, m_ts);
            end
            repeat (10) @(posedge clock);
        end
    endtask

    initial begin
        test_reset();
        test_autostart();
        test_bad_ts();
        test_waitreq();
        test_timeout();
        test_zero_latency();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
